// File: rtl/lpe_multi_match_if.sv
// lpe_multi_match_if: match-vector input and matching-address output handshakes
interface lpe_multi_match_if #(parameter int K = 256);
    localparam int AW = $clog2(K);
    logic          ma_valid;
    logic          ma_ready;
    logic [0:K-1]  ma;
    logic          pma_valid;
    logic          pma_ready;
    logic [AW-1:0] pma;
    logic          pma_last;
    logic          no_match;
    modport master (output ma_valid, ma, pma_ready,
                    input  ma_ready, pma_valid, pma, pma_last, no_match);
    modport slave  (input  ma_valid, ma, pma_ready,
                    output ma_ready, pma_valid, pma, pma_last, no_match);
endinterface

// File: rtl/lpe_multi_match.sv
// lpe_multi_match: streams every set index of a match vector, lowest index first, one per beat.
// Defining LPE_MATCH_COUNT_EN adds match_cnt, the popcount of the last accepted vector.
module lpe_multi_match #(parameter int K = 256) (
    input logic                  clk,
    input logic                  rst,
    lpe_multi_match_if.slave     bus
`ifdef LPE_MATCH_COUNT_EN
    , output logic [$clog2(K):0] match_cnt
`endif
);
    localparam int AW = $clog2(K);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t        state_q, state_d;
    logic [0:K-1]  r_q, r_d, r_clr;
    logic [AW-1:0] pma_q, pma_d, enc;
    logic          nm_q, nm_d, last, scan, acc;
    assign scan = (state_q == SCAN);
    assign acc  = bus.ma_valid && bus.ma_ready;
    always_comb begin
        enc = '0;
        for (int i = K - 1; i >= 0; i--) if (r_q[i]) enc = AW'(i);
        r_clr = r_q;
        r_clr[enc] = 1'b0;
        last = (r_clr == '0);
    end
    // pma is live from R while scanning and holds the last emitted index otherwise
    assign bus.ma_ready  = (state_q == IDLE) && !rst;
    assign bus.pma_valid = scan;
    assign bus.pma       = scan ? enc : pma_q;
    assign bus.pma_last  = scan && last;
    assign bus.no_match  = nm_q;
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        pma_d   = pma_q;
        nm_d    = 1'b0;
        if (!scan && acc) begin
            r_d     = (|bus.ma) ? bus.ma : r_q;
            state_d = (|bus.ma) ? SCAN : IDLE;
            nm_d    = ~|bus.ma;
        end else if (scan && bus.pma_ready) begin
            r_d     = r_clr;
            pma_d   = enc;
            state_d = last ? IDLE : SCAN;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            pma_q   <= '0;
            nm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            pma_q   <= pma_d;
            nm_q    <= nm_d;
        end
    end
`ifdef LPE_MATCH_COUNT_EN
    logic [AW:0] cnt_q, pop;
    always_comb begin
        pop = '0;
        for (int i = 0; i < K; i++) pop = pop + (AW + 1)'(bus.ma[i]);
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (!scan && acc) cnt_q <= pop;
    end
    assign match_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_lpe_multi_match.sv
// tb_lpe_multi_match: directed vectors against K=8 and K=256 instances of lpe_multi_match
module tb_lpe_multi_match;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    lpe_multi_match_if #(.K(8))   b8 ();
    lpe_multi_match_if #(.K(256)) b256 ();
`ifdef LPE_MATCH_COUNT_EN
    logic [3:0] cnt8;
    logic [8:0] cnt256;
`endif
    lpe_multi_match #(.K(8)) u8 (
        .clk(clk), .rst(rst), .bus(b8)
`ifdef LPE_MATCH_COUNT_EN
        , .match_cnt(cnt8)
`endif
    );
    lpe_multi_match #(.K(256)) u256 (
        .clk(clk), .rst(rst), .bus(b256)
`ifdef LPE_MATCH_COUNT_EN
        , .match_cnt(cnt256)
`endif
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic accept8(input logic [0:7] v);
        b8.ma = v;
        b8.ma_valid = 1'b1;
        cyc();
        b8.ma_valid = 1'b0;
    endtask
    initial begin
        b8.ma_valid = 1'b0; b8.ma = '0; b8.pma_ready = 1'b1;
        b256.ma_valid = 1'b0; b256.ma = '0; b256.pma_ready = 1'b1;
        cyc(); cyc();
        chk("rst_ready", b8.ma_ready, 0);
        chk("rst_valid", b8.pma_valid, 0);
        chk("rst_last", b8.pma_last, 0);
        chk("rst_nomatch", b8.no_match, 0);
        chk("rst_pma", b8.pma, 0);
`ifdef LPE_MATCH_COUNT_EN
        chk("rst_cnt", cnt8, 0);
`endif
        rst = 1'b0;
        #1;
        chk("idle_ready", b8.ma_ready, 1);
        // ma[2], ma[5]
        accept8(8'b0010_0100);
        chk("mm_v1", b8.pma_valid, 1);
        chk("mm_pma1", b8.pma, 2);
        chk("mm_last1", b8.pma_last, 0);
        chk("mm_busy", b8.ma_ready, 0);
        cyc();
        chk("mm_pma2", b8.pma, 5);
        chk("mm_last2", b8.pma_last, 1);
        cyc();
        chk("mm_done_v", b8.pma_valid, 0);
        chk("mm_done_rdy", b8.ma_ready, 1);
        chk("mm_hold_pma", b8.pma, 5);
        accept8(8'b0000_0000);
        chk("nm_pulse", b8.no_match, 1);
        chk("nm_valid", b8.pma_valid, 0);
        chk("nm_ready", b8.ma_ready, 1);
        cyc();
        chk("nm_end", b8.no_match, 0);
        chk("nm_valid2", b8.pma_valid, 0);
        b8.pma_ready = 1'b0;
        accept8(8'b1000_0001);
        for (int i = 0; i < 3; i++) begin
            chk("bp_pma", b8.pma, 0);
            chk("bp_last", b8.pma_last, 0);
            chk("bp_valid", b8.pma_valid, 1);
            cyc();
        end
        chk("bp_pma_rel", b8.pma, 0);
        b8.pma_ready = 1'b1;
        cyc();
        chk("bp_pma7", b8.pma, 7);
        chk("bp_last7", b8.pma_last, 1);
        cyc();
        chk("bp_done", b8.pma_valid, 0);
        accept8(8'b1111_1111);
        chk("rl_pma0", b8.pma, 0);
        cyc();
        chk("rl_pma1", b8.pma, 1);
        cyc();
        rst = 1'b1;
        cyc();
        chk("rl_valid", b8.pma_valid, 0);
        chk("rl_rdy_rst", b8.ma_ready, 0);
        chk("rl_pma", b8.pma, 0);
        rst = 1'b0;
        #1;
        chk("rl_rdy", b8.ma_ready, 1);
        cyc();
        chk("rl_nobeat", b8.pma_valid, 0);
        accept8(8'b0000_0001);
        chk("rl_new_v", b8.pma_valid, 1);
        chk("rl_new_pma", b8.pma, 7);
        chk("rl_new_last", b8.pma_last, 1);
        cyc();
        chk("rl_new_done", b8.pma_valid, 0);
`ifdef LPE_MATCH_COUNT_EN
        accept8(8'b0110_1001);
        for (int i = 0; i < 4; i++) begin
            chk("cnt_scan", cnt8, 4);
            cyc();
        end
        chk("cnt_idle", cnt8, 4);
        chk("cnt_idle_v", b8.pma_valid, 0);
        accept8(8'b0000_0000);
        chk("cnt_zero", cnt8, 0);
`endif
        b256.ma = '1;
        b256.ma_valid = 1'b1;
        cyc();
        b256.ma_valid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk("full_valid", b256.pma_valid, 1);
            chk("full_pma", b256.pma, i);
            chk("full_last", b256.pma_last, (i == 255) ? 1 : 0);
            chk("full_busy", b256.ma_ready, 0);
            cyc();
        end
        chk("full_done", b256.pma_valid, 0);
        chk("full_rdy", b256.ma_ready, 1);
`ifdef LPE_MATCH_COUNT_EN
        chk("full_cnt", cnt256, 256);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lpe_multi_match.md
Name: lpe_multi_match

Overview:
- Sequential successor to the single-shot lowest-index priority encoder in the SRAM-based TCAM search path.
- Accepts one K-bit match vector per lookup and streams out every matching address, highest priority (lowest index) first, one per cycle.
- Uses a valid/ready handshake on both sides.
- Sits between the TCAM match-line aggregation and the action/result memory lookup, so multi-match lookups can be resolved in full.

Parameters:
- K, 256, number of TCAM entries (width of the match vector); K >= 2.
- AW, $clog2(K), address width of emitted index; derived, not to be overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ma_valid  in  1  match vector valid.
- ma_ready  out  1  block can accept a new vector.
- ma  in  [0:K-1]  match vector; ma[i]=1 means entry i matched; index 0 is highest priority.
- pma_valid  out  1  pma holds a valid matching address.
- pma_ready  in  1  downstream accepts pma.
- pma  out  AW  matching address (binary index i of ma[i]).
- pma_last  out  1  current pma is the final match of this vector.
- no_match  out  1  one-cycle pulse: accepted vector was all zeros.

Behaviour:
- Reset, synchronous: on a clk edge with rst=1, the block enters IDLE and clears the residual register R, pma_valid, pma_last, no_match and pma to 0. While rst=1, ma_ready=0.
- Reset mid-scan: the current vector is abandoned with no further beats. The next cycle after reset deasserts is IDLE.
- States: IDLE, SCAN.
- ma_ready = (state==IDLE) && !rst. The block never accepts a new vector while scanning; there is no overlap between vectors.
- IDLE, on ma_valid && ma_ready (cycle t):
  - ma != 0: R <= ma; next state SCAN.
  - ma == 0: no_match=1 during cycle t+1 only; R unchanged; stay IDLE. A new vector may be accepted in cycle t+1.
- SCAN:
  - pma_valid=1.
  - pma = lowest index i with R[i]=1, computed combinationally from registered R.
  - pma_last=1 iff R has exactly one bit set.
- Beat transfer on pma_valid && pma_ready: clear R[pma].
  - If pma_last: R becomes 0 and the next state is IDLE; pma_valid=0 in the next cycle.
  - Otherwise stay in SCAN; the next-priority address appears in the next cycle.
- Stall: while pma_valid && !pma_ready, pma, pma_last and R hold stable.
- Latency and throughput:
  - First pma_valid appears one cycle after acceptance.
  - Sustains one address per cycle with pma_ready held high.
  - A vector with N matches occupies N cycles in SCAN.
  - The next vector can be accepted in the cycle after the last beat transfers.
- Outputs in IDLE: pma_valid=0, pma_last=0. pma holds its last value and is don't-care to the consumer.
- Width rules: pma is an unsigned index, zero-extended to AW. For non-power-of-2 K, indices >= K never appear.
- All-ones vector: emits 0,1,...,K-1 in order, with pma_last set only on K-1.

Optional Feature:
- Macro LPE_MATCH_COUNT_EN.
- When defined: adds output port match_cnt, direction out, width AW+1.
  - Registered popcount of the accepted vector, valid from cycle t+1.
  - Held until the next acceptance. Equals 0 on a no_match acceptance. Resets to 0.
- When undefined: the port and the popcount logic are absent. All other behaviour is identical.

Test Plan:
- Reset under load: K=8, ma=8'b1111_1111 accepted, rst asserted after the 2nd beat -> next cycle pma_valid=0, ma_ready=1 after rst drops, no further beats; new vector 8'b0000_0001 yields pma=7, pma_last=1.
- Single and multiple matches: K=8, ma=8'b0010_0100 (ma[2], ma[5]), pma_ready=1 -> cycle t+1 pma=2, pma_last=0; t+2 pma=5, pma_last=1; t+3 pma_valid=0, ma_ready=1.
- No match: ma=8'b0 accepted -> no_match=1 for exactly one cycle, pma_valid never asserts, ma_ready stays 1.
- Backpressure: ma=8'b1000_0001, pma_ready=0 for 3 cycles -> pma=0 held stable, pma_last=0 for 3 cycles; release -> pma=0 transfers, then pma=7, pma_last=1.
- Full vector, K=256: all-ones input -> 256 consecutive beats 0..255, pma_last only on 255; ma_ready=0 throughout the scan.
- LPE_MATCH_COUNT_EN defined: ma=8'b0110_1001 -> match_cnt=4 from t+1, held through the scan; a later all-zero accept -> match_cnt=0.
